bus_scratch_ram: RTL and testbench
==================================

Name: bus_scratch_ram

Overview:
- Bus slave scratch RAM sitting directly downstream of the JTAG bus master on the shared system bus.
- Consumes the master's single and burst read/write transactions and returns read data.
- Gives the JTAG debug path a known-good memory target for bring-up and regression tests.
- Drives its bus outputs only while it owns the current transaction; all outputs are 0 otherwise (wired-OR bus).

Parameters:
- BASE_ADDRESS, 32'h4000_0000, byte base address of the RAM window. Aligned to the window size.
- SIZE_WORDS, 256, depth in 32-bit words. Power of two, 16..4096. INDEX_BITS = log2(SIZE_WORDS).

Ports:
- system_clock  in  1  single clock
- system_reset  in  1  synchronous, active-high reset
- address_dataIN  in  32  address on begin cycle; write data on data-valid cycles
- byte_enableIN  in  4  byte lanes for writes, sampled per beat
- burst_sizeIN  in  8  beats minus one, sampled on begin cycle
- read_n_writeIN  in  1  1 = read, 0 = write, sampled on begin cycle
- begin_transactionIN  in  1  start of transaction, one-cycle pulse
- end_transactionIN  in  1  master ends write, or aborts read
- data_validIN  in  1  write beat present
- busyIN  in  1  master stalls read data
- address_dataOUT  out  32  read data, 0 when not valid
- end_transactionOUT  out  1  slave ends read or error response
- data_validOUT  out  1  read beat present
- busyOUT  out  1  slave stall; tied 0 (RAM never stalls)
- errorOUT  out  1  transaction rejected

Behaviour:
- Reset: synchronous, active-high. State goes to IDLE; all outputs 0. RAM contents are not cleared.
- Select: begin_transactionIN=1 and address_dataIN[31:INDEX_BITS+2] == BASE_ADDRESS[31:INDEX_BITS+2].
  - index = address_dataIN[INDEX_BITS+1:2]; bits [1:0] are ignored.
  - beats = burst_sizeIN+1.
  - Unselected begins are ignored and the block stays in IDLE.
- Range check: if index + burst_sizeIN > SIZE_WORDS-1 (computed at INDEX_BITS+9 width), the transaction is in error. There is no wrap-around.
- IDLE:
  - Selected read -> READ, or ERR_RD on a range error.
  - Selected write -> WRITE, or ERR_WR on a range error.
  - begin_transactionIN is honoured only in IDLE.
- WRITE:
  - Each cycle with data_validIN=1 and remaining>0: write address_dataIN to RAM[index] with byte_enableIN lane masking, then index+1 and remaining-1.
  - Beats beyond the burst count are ignored.
  - end_transactionIN=1 -> IDLE in the next cycle. A data beat in the same cycle is still written.
- READ:
  - Begin in cycle T -> first data_validOUT=1 in cycle T+2 (synchronous RAM, one-cycle read).
  - Then one beat per cycle while busyIN=0.
  - If data_validOUT=1 and busyIN=1: hold address_dataOUT and data_validOUT unchanged; the index does not advance.
  - A beat completes when data_validOUT=1 and busyIN=0.
  - After the last beat completes: end_transactionOUT=1 for exactly one cycle in the following cycle, data_validOUT=0, then IDLE.
  - end_transactionIN=1 during READ aborts: next cycle all outputs 0, state IDLE, no end_transactionOUT.
- ERR_RD: in cycle T+1, errorOUT=1 and end_transactionOUT=1 for one cycle, no data, then IDLE.
- ERR_WR: in cycle T+1, errorOUT=1 for one cycle. No RAM writes. Stays until end_transactionIN=1, then IDLE.
- Reset asserted mid-transaction: IDLE next cycle, outputs 0. A beat presented in the reset cycle is not written.
- busyOUT is always 0.

Test Plan:
- Single write then read:
  - Write 0xDEADBEEF at 0x4000_0010, be=4'hF, burst 0.
  - Read the same address -> data_validOUT at T+2 with 0xDEADBEEF, end_transactionOUT at T+3, errorOUT=0.
- Byte enables:
  - Write 0x11223344 with be=4'hF, then 0xAABBCCDD with be=4'b0101 at 0x4000_0000.
  - Read back -> 0x11BB33DD.
- Burst with stall:
  - Write 8 beats 0..7 from 0x4000_0020.
  - Read burst_size=7 with busyIN=1 on the 3rd beat for 2 cycles -> values 0..7 in order, beat 2 held for 3 cycles, single end_transactionOUT.
- Range error:
  - Read at index 254, burst_size=3, SIZE_WORDS=256 -> errorOUT=1 and end_transactionOUT=1 at T+1, no data_validOUT.
  - Write with the same range -> errorOUT pulse; RAM[254], RAM[255] unchanged.
- Unselected address:
  - Read at 0x5000_0000 -> all outputs stay 0 for 10 cycles.
- Abort and reset:
  - end_transactionIN during a 16-beat read after beat 4 -> outputs 0 next cycle, IDLE.
  - system_reset mid-write -> a later read shows only the beats written before reset.

Source files
------------

// File: rtl/bus_scratch_ram.sv
// Bus-slave scratch RAM for the JTAG debug master: single/burst reads and writes, range-checked, no wrap.
// Read data appears two cycles after begin, one beat per cycle; busyIN holds the current beat; never stalls writes.
module bus_scratch_ram #(
  parameter logic [31:0] BASE_ADDRESS = 32'h4000_0000,
  parameter int          SIZE_WORDS   = 256
) (
  input  logic        system_clock,
  input  logic        system_reset,
  input  logic [31:0] address_dataIN,
  input  logic [3:0]  byte_enableIN,
  input  logic [7:0]  burst_sizeIN,
  input  logic        read_n_writeIN,
  input  logic        begin_transactionIN,
  input  logic        end_transactionIN,
  input  logic        data_validIN,
  input  logic        busyIN,
  output logic [31:0] address_dataOUT,
  output logic        end_transactionOUT,
  output logic        data_validOUT,
  output logic        busyOUT,
  output logic        errorOUT
);

  localparam int INDEX_BITS = $clog2(SIZE_WORDS);
  localparam int CW         = INDEX_BITS + 9;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WRITE  = 3'd1;
  localparam logic [2:0] S_READ   = 3'd2;
  localparam logic [2:0] S_ERR_RD = 3'd3;
  localparam logic [2:0] S_ERR_WR = 3'd4;

  logic [31:0]           ram [SIZE_WORDS];
  logic [2:0]            state;
  logic [INDEX_BITS-1:0] idx;
  logic [8:0]            remaining;
  logic [31:0]           rd_q;
  logic                  dv_q;
  logic                  end_q;
  logic                  err_q;

  logic [INDEX_BITS-1:0] begin_idx;
  logic [CW-1:0]         last_idx;
  logic                  selected;
  logic                  range_err;
  logic                  ram_wr;
  logic                  rd_issue;

  assign begin_idx = address_dataIN[INDEX_BITS+1:2];
  assign selected  = begin_transactionIN &&
                     (address_dataIN[31:INDEX_BITS+2] == BASE_ADDRESS[31:INDEX_BITS+2]);
  assign last_idx  = CW'(begin_idx) + CW'(burst_sizeIN);
  assign range_err = last_idx > CW'(SIZE_WORDS - 1);

  assign ram_wr   = (state == S_WRITE) && data_validIN && (remaining != 9'd0) && !system_reset;
  // Fetch the next word whenever the output stage is empty or its beat is being accepted.
  assign rd_issue = (state == S_READ) && !end_transactionIN && (remaining != 9'd0) &&
                    !(dv_q && busyIN);

  always_ff @(posedge system_clock) begin
    if (ram_wr) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_enableIN[b]) ram[idx][8*b +: 8] <= address_dataIN[8*b +: 8];
      end
    end
    if (rd_issue) rd_q <= ram[idx];
  end

  always_ff @(posedge system_clock) begin
    if (system_reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      remaining <= '0;
      dv_q      <= 1'b0;
      end_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      end_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        S_IDLE: begin
          dv_q <= 1'b0;
          if (selected) begin
            idx       <= begin_idx;
            remaining <= {1'b0, burst_sizeIN} + 9'd1;
            if (read_n_writeIN) begin
              if (range_err) begin
                state <= S_ERR_RD;
                err_q <= 1'b1;
                end_q <= 1'b1;
              end else begin
                state <= S_READ;
              end
            end else begin
              if (range_err) begin
                state <= S_ERR_WR;
                err_q <= 1'b1;
              end else begin
                state <= S_WRITE;
              end
            end
          end
        end
        S_WRITE: begin
          if (ram_wr) begin
            idx       <= idx + 1'b1;
            remaining <= remaining - 9'd1;
          end
          if (end_transactionIN) state <= S_IDLE;
        end
        S_READ: begin
          if (end_transactionIN) begin
            state <= S_IDLE;
            dv_q  <= 1'b0;
          end else if (rd_issue) begin
            dv_q      <= 1'b1;
            idx       <= idx + 1'b1;
            remaining <= remaining - 9'd1;
          end else if (dv_q && !busyIN) begin
            // Last beat accepted: close with a single end pulse.
            dv_q  <= 1'b0;
            end_q <= 1'b1;
            state <= S_IDLE;
          end
        end
        S_ERR_RD: state <= S_IDLE;
        S_ERR_WR: if (end_transactionIN) state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign address_dataOUT    = dv_q ? rd_q : 32'h0;
  assign data_validOUT      = dv_q;
  assign end_transactionOUT = end_q;
  assign errorOUT           = err_q;
  assign busyOUT            = 1'b0;

endmodule

// File: tb/tb_bus_scratch_ram.sv
// Directed bench for bus_scratch_ram: vector table of single writes/reads plus hand-written burst, stall, error, abort and reset sequences.
module tb_bus_scratch_ram;

  logic        system_clock = 1'b0;
  logic        system_reset;
  logic [31:0] address_dataIN;
  logic [3:0]  byte_enableIN;
  logic [7:0]  burst_sizeIN;
  logic        read_n_writeIN;
  logic        begin_transactionIN;
  logic        end_transactionIN;
  logic        data_validIN;
  logic        busyIN;
  logic [31:0] address_dataOUT;
  logic        end_transactionOUT;
  logic        data_validOUT;
  logic        busyOUT;
  logic        errorOUT;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] rd_got [16];

  typedef struct {
    logic        is_wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] dat;
  } vec_t;
  vec_t vecs [12];

  bus_scratch_ram #(.BASE_ADDRESS(32'h4000_0000), .SIZE_WORDS(256)) dut (
    .system_clock       (system_clock),
    .system_reset       (system_reset),
    .address_dataIN     (address_dataIN),
    .byte_enableIN      (byte_enableIN),
    .burst_sizeIN       (burst_sizeIN),
    .read_n_writeIN     (read_n_writeIN),
    .begin_transactionIN(begin_transactionIN),
    .end_transactionIN  (end_transactionIN),
    .data_validIN       (data_validIN),
    .busyIN             (busyIN),
    .address_dataOUT    (address_dataOUT),
    .end_transactionOUT (end_transactionOUT),
    .data_validOUT      (data_validOUT),
    .busyOUT            (busyOUT),
    .errorOUT           (errorOUT)
  );

  always #5 system_clock = ~system_clock;

  task automatic tick();
    @(posedge system_clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic write_burst(input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] d0, input int n);
    address_dataIN      = addr;
    read_n_writeIN      = 1'b0;
    burst_sizeIN        = 8'(n - 1);
    byte_enableIN       = be;
    begin_transactionIN = 1'b1;
    tick();
    begin_transactionIN = 1'b0;
    for (int i = 0; i < n; i++) begin
      address_dataIN    = d0 + 32'(i);
      data_validIN      = 1'b1;
      end_transactionIN = (i == n - 1);
      tick();
    end
    data_validIN      = 1'b0;
    end_transactionIN = 1'b0;
    address_dataIN    = 32'h0;
  endtask

  // Stall-free read; checks beat timing and the end pulse, leaves data in rd_got.
  task automatic read_burst(input logic [31:0] addr, input int n, input string tag);
    for (int i = 0; i < 16; i++) rd_got[i] = 32'hBAD0_BAD0;
    address_dataIN      = addr;
    read_n_writeIN      = 1'b1;
    burst_sizeIN        = 8'(n - 1);
    begin_transactionIN = 1'b1;
    tick();
    begin_transactionIN = 1'b0;
    read_n_writeIN      = 1'b0;
    address_dataIN      = 32'h0;
    for (int k = 1; k <= n + 2; k++) begin
      chk($sformatf("%s dv k%0d", tag, k), 32'(data_validOUT), 32'(k >= 2 && k <= n + 1));
      chk($sformatf("%s end k%0d", tag, k), 32'(end_transactionOUT), 32'(k == n + 2));
      chk($sformatf("%s err k%0d", tag, k), 32'(errorOUT), 32'h0);
      if (data_validOUT && k >= 2) rd_got[k-2] = address_dataOUT;
      tick();
    end
  endtask

  initial begin
    system_reset        = 1'b1;
    address_dataIN      = 32'h0;
    byte_enableIN       = 4'hF;
    burst_sizeIN        = 8'h0;
    read_n_writeIN      = 1'b0;
    begin_transactionIN = 1'b0;
    end_transactionIN   = 1'b0;
    data_validIN        = 1'b0;
    busyIN              = 1'b0;

    vecs[0]  = '{1'b1, 32'h4000_0010, 4'hF, 32'hDEAD_BEEF};
    vecs[1]  = '{1'b0, 32'h4000_0010, 4'hF, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h4000_0000, 4'hF, 32'h1122_3344};
    vecs[3]  = '{1'b1, 32'h4000_0000, 4'h5, 32'hAABB_CCDD};
    vecs[4]  = '{1'b0, 32'h4000_0000, 4'hF, 32'h11BB_33DD};
    vecs[5]  = '{1'b1, 32'h4000_0013, 4'hF, 32'hCAFE_F00D};
    vecs[6]  = '{1'b0, 32'h4000_0010, 4'hF, 32'hCAFE_F00D};
    vecs[7]  = '{1'b1, 32'h4000_0004, 4'hF, 32'h0000_0000};
    vecs[8]  = '{1'b1, 32'h4000_0004, 4'hA, 32'hFFFF_FFFF};
    vecs[9]  = '{1'b0, 32'h4000_0004, 4'hF, 32'hFF00_FF00};
    vecs[10] = '{1'b1, 32'h4000_03FC, 4'hF, 32'h5A5A_5A5A};
    vecs[11] = '{1'b0, 32'h4000_03FC, 4'hF, 32'h5A5A_5A5A};

    tick(); tick(); tick();
    chk("reset outputs", {address_dataOUT[27:0], data_validOUT, end_transactionOUT, busyOUT, errorOUT}, 32'h0);
    chk("reset data", address_dataOUT, 32'h0);
    system_reset = 1'b0;
    tick();

    for (int v = 0; v < 12; v++) begin
      if (vecs[v].is_wr) begin
        write_burst(vecs[v].addr, vecs[v].be, vecs[v].dat, 1);
      end else begin
        read_burst(vecs[v].addr, 1, $sformatf("vec%0d", v));
        chk($sformatf("vec%0d data", v), rd_got[0], vecs[v].dat);
      end
    end

    // Burst read with busyIN on the third beat for two cycles.
    write_burst(32'h4000_0020, 4'hF, 32'h0, 8);
    address_dataIN = 32'h4000_0020; read_n_writeIN = 1'b1; burst_sizeIN = 8'd7;
    begin_transactionIN = 1'b1;
    tick();
    begin_transactionIN = 1'b0; address_dataIN = 32'h0;
    for (int k = 1; k <= 13; k++) begin
      logic        e_dv;
      logic [31:0] e_dat;
      busyIN = (k == 4 || k == 5);
      e_dv   = (k >= 2 && k <= 11);
      e_dat  = (k <= 3) ? 32'(k - 2) : (k <= 6) ? 32'd2 : 32'(k - 4);
      if (!e_dv) e_dat = 32'h0;
      chk($sformatf("stall dv k%0d", k), 32'(data_validOUT), 32'(e_dv));
      chk($sformatf("stall dat k%0d", k), address_dataOUT, e_dat);
      chk($sformatf("stall end k%0d", k), 32'(end_transactionOUT), 32'(k == 12));
      tick();
    end
    busyIN = 1'b0;

    // Out-of-range read: error and end together, no data.
    address_dataIN = 32'h4000_03F8; read_n_writeIN = 1'b1; burst_sizeIN = 8'd3;
    begin_transactionIN = 1'b1;
    tick();
    begin_transactionIN = 1'b0; address_dataIN = 32'h0;
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("rderr err k%0d", k), 32'(errorOUT), 32'(k == 1));
      chk($sformatf("rderr end k%0d", k), 32'(end_transactionOUT), 32'(k == 1));
      chk($sformatf("rderr dv k%0d", k), 32'(data_validOUT), 32'h0);
      tick();
    end

    // Out-of-range write must leave the last two words untouched.
    write_burst(32'h4000_03F8, 4'hF, 32'h254, 1);
    write_burst(32'h4000_03FC, 4'hF, 32'h255, 1);
    address_dataIN = 32'h4000_03F8; read_n_writeIN = 1'b0; burst_sizeIN = 8'd3;
    begin_transactionIN = 1'b1;
    tick();
    begin_transactionIN = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      address_dataIN    = 32'hEEEE_0000 + 32'(k);
      data_validIN      = 1'b1;
      end_transactionIN = (k == 4);
      chk($sformatf("wrerr err k%0d", k), 32'(errorOUT), 32'(k == 1));
      chk($sformatf("wrerr end k%0d", k), 32'(end_transactionOUT), 32'h0);
      tick();
    end
    data_validIN = 1'b0; end_transactionIN = 1'b0; address_dataIN = 32'h0;
    chk("wrerr err after", 32'(errorOUT), 32'h0);
    read_burst(32'h4000_03F8, 2, "wrerr rb");
    chk("wrerr ram254", rd_got[0], 32'h254);
    chk("wrerr ram255", rd_got[1], 32'h255);

    // Unselected address: the bus stays quiet.
    address_dataIN = 32'h5000_0000; read_n_writeIN = 1'b1; burst_sizeIN = 8'd0;
    begin_transactionIN = 1'b1;
    tick();
    begin_transactionIN = 1'b0; address_dataIN = 32'h0; read_n_writeIN = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("unsel data k%0d", k), address_dataOUT, 32'h0);
      chk($sformatf("unsel ctl k%0d", k),
          {28'h0, data_validOUT, end_transactionOUT, busyOUT, errorOUT}, 32'h0);
      tick();
    end

    // Abort a 16-beat read right after beat 4.
    write_burst(32'h4000_0100, 4'hF, 32'h100, 16);
    address_dataIN = 32'h4000_0100; read_n_writeIN = 1'b1; burst_sizeIN = 8'd15;
    begin_transactionIN = 1'b1;
    tick();
    begin_transactionIN = 1'b0; address_dataIN = 32'h0; read_n_writeIN = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      logic e_dv;
      e_dv = (k >= 2 && k <= 6);
      end_transactionIN = (k == 6);
      chk($sformatf("abort dv k%0d", k), 32'(data_validOUT), 32'(e_dv));
      chk($sformatf("abort dat k%0d", k), address_dataOUT, e_dv ? 32'h100 + 32'(k - 2) : 32'h0);
      chk($sformatf("abort end k%0d", k), 32'(end_transactionOUT), 32'h0);
      tick();
    end
    end_transactionIN = 1'b0;
    read_burst(32'h4000_0108, 1, "post-abort");
    chk("post-abort data", rd_got[0], 32'h102);

    // Reset in the middle of a write burst.
    write_burst(32'h4000_0190, 4'hF, 32'hFFFF_0000, 4);
    address_dataIN = 32'h4000_0190; read_n_writeIN = 1'b0; burst_sizeIN = 8'd3;
    begin_transactionIN = 1'b1;
    tick();
    begin_transactionIN = 1'b0;
    data_validIN = 1'b1;
    address_dataIN = 32'hC0; tick();
    address_dataIN = 32'hC1; tick();
    address_dataIN = 32'hC2; system_reset = 1'b1; tick();
    system_reset = 1'b0;
    address_dataIN = 32'hC3;
    chk("rst mid-wr ctl", {28'h0, data_validOUT, end_transactionOUT, busyOUT, errorOUT}, 32'h0);
    tick();
    data_validIN = 1'b0; address_dataIN = 32'h0;
    read_burst(32'h4000_0190, 4, "rst rb");
    chk("rst beat0", rd_got[0], 32'hC0);
    chk("rst beat1", rd_got[1], 32'hC1);
    chk("rst beat2", rd_got[2], 32'hFFFF_0002);
    chk("rst beat3", rd_got[3], 32'hFFFF_0003);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
